instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch_pkg.sv | 23 ++
 rtl/fetch_queue.sv | 61 ++++++
 rtl/instruction_fetch.sv | 64 ++++++
 tb/tb_instruction_fetch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the instruction fetch slice.
package instruction_fetch_pkg;

  // Word and byte-address width used throughout the fetch path.
  localparam int unsigned WORD_WIDTH = 32;

  // Sequential fetch advances one 32-bit word at a time.
  localparam logic [WORD_WIDTH-1:0] PC_INCREMENT = 32'd4;

  // One queue entry carries the PC alongside the raw instruction bits.
  typedef struct packed {
    logic [WORD_WIDTH-1:0] pc;
    logic [WORD_WIDTH-1:0] instruction;
  } fetch_entry_t;

  localparam int unsigned ENTRY_WIDTH = $bits(fetch_entry_t);

  // Force a byte address down to its containing word.
  function automatic logic [WORD_WIDTH-1:0] align_word(input logic [WORD_WIDTH-1:0] addr);
    return {addr[WORD_WIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small circular FIFO holding fetched entries between imem and decode.
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_WIDTH = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]     storage_q [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q;
  logic [PTR_WIDTH-1:0] rd_ptr_q;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 do_push;
  logic                 do_pop;

  assign full      = (count_q == CNT_WIDTH'(DEPTH));
  assign empty     = (count_q == '0);
  assign do_pop    = pop & ~empty;
  // A pop frees the head slot in the same edge, so a full queue may still accept.
  assign do_push   = push & (~full | do_pop);
  assign head_data = storage_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping; flush discards everything at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_WIDTH'(1);
        2'b01:   count_q <= count_q - CNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage needs no reset: contents are only observed while non-empty.
  always_ff @(posedge clock) begin
    if (do_push && !flush) storage_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, presents it to instruction memory and queues
// {pc, instruction} pairs for decode. Redirects flush the queue.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [WORD_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned           DEPTH    = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  output logic [WORD_WIDTH-1:0] imem_address,
  input  logic [WORD_WIDTH-1:0] imem_instruction,
  input  logic                  redirect_valid,
  input  logic [WORD_WIDTH-1:0] redirect_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_instruction,
  output logic [WORD_WIDTH-1:0] out_pc
);

  logic [WORD_WIDTH-1:0] pc_q;
  logic                  q_full;
  logic                  q_empty;
  logic                  pop;
  logic                  push;
  fetch_entry_t          push_entry;
  fetch_entry_t          head_entry;

  assign imem_address    = pc_q;
  assign out_valid       = ~q_empty;
  assign pop             = out_valid & out_ready;
  // No fetch during a redirect cycle; otherwise fetch whenever a slot is or becomes free.
  assign push            = ~redirect_valid & (~q_full | pop);
  assign push_entry      = '{pc: pc_q, instruction: imem_instruction};
  assign out_pc          = head_entry.pc;
  assign out_instruction = head_entry.instruction;

  // PC: jump to the aligned redirect target, else step past each fetched word.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_q <= RESET_PC;
    end else if (redirect_valid) begin
      pc_q <= align_word(redirect_pc);
    end else if (push) begin
      pc_q <= pc_q + PC_INCREMENT;
    end
  end

  fetch_queue #(
    .WIDTH (ENTRY_WIDTH),
    .DEPTH (DEPTH)
  ) u_fetch_queue (
    .clock     (clock),
    .reset_n   (reset_n),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data (head_entry),
    .full      (q_full),
    .empty     (q_empty)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with an in-order scoreboard of the
// expected {pc, instruction} stream. Memory word i reads 32'hA000_0000 + i.
module tb_instruction_fetch;

  logic        clock;
  logic        reset_n;
  logic [31:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instruction;
  logic [31:0] out_pc;

  // Second instance exercising PC wraparound from the top of the address space.
  logic [31:0] w_imem_address;
  logic [31:0] w_imem_instruction;
  logic        w_redirect_valid;
  logic [31:0] w_redirect_pc;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [31:0] w_out_instruction;
  logic [31:0] w_out_pc;

  int checks;
  int errors;
  logic [63:0] exp_q [$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA000_0000 + {2'b00, a[31:2]};
  endfunction

  assign imem_instruction   = mem_word(imem_address);
  assign w_imem_instruction = mem_word(w_imem_address);

  instruction_fetch dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .imem_address     (imem_address),
    .imem_instruction (imem_instruction),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instruction  (out_instruction),
    .out_pc           (out_pc)
  );

  instruction_fetch #(
    .RESET_PC (32'hFFFF_FFFC)
  ) dut_w (
    .clock            (clock),
    .reset_n          (reset_n),
    .imem_address     (w_imem_address),
    .imem_instruction (w_imem_instruction),
    .redirect_valid   (w_redirect_valid),
    .redirect_pc      (w_redirect_pc),
    .out_valid        (w_out_valid),
    .out_ready        (w_out_ready),
    .out_instruction  (w_out_instruction),
    .out_pc           (w_out_pc)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected stream from a (re)start address, in fetch order.
  task automatic sb_load(input logic [31:0] start, input int n);
    logic [31:0] a;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      a = start + 32'(4 * k);
      exp_q.push_back({a, mem_word(a)});
    end
  endtask

  // Called once inputs for the coming edge are set: if the head will be
  // accepted, it must match the next expected entry.
  task automatic accept_check();
    logic [63:0] e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_underflow observed=%h expected=none", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", out_pc, e[63:32]);
        chk("sb_instr", out_instruction, e[31:0]);
      end
    end
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset_n          = 1'b0;
    redirect_valid   = 1'b0;
    redirect_pc      = 32'h0;
    out_ready        = 1'b0;
    w_redirect_valid = 1'b0;
    w_redirect_pc    = 32'h0;
    w_out_ready      = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", imem_address, 32'h0);
    chk("rst_w_addr", w_imem_address, 32'hFFFF_FFFC);

    // Release with out_ready held high: one instruction per cycle
    out_ready = 1'b1;
    reset_n   = 1'b1;
    sb_load(32'h0, 32);
    chk("rel_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clock);
      #1;
      chk("stream_valid", 32'(out_valid), 32'd1);
      chk("wrap_valid", 32'(w_out_valid), 32'd1);
      if (i == 0) begin
        chk("wrap_pc0", w_out_pc, 32'hFFFF_FFFC);
        chk("wrap_instr0", w_out_instruction, 32'hDFFF_FFFF);
      end
      if (i == 1) begin
        chk("wrap_pc1", w_out_pc, 32'h0000_0000);
        chk("wrap_instr1", w_out_instruction, 32'hA000_0000);
      end
      accept_check();
    end

    // Asynchronous reset between edges
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_valid", 32'(out_valid), 32'd0);
    chk("async_addr", imem_address, 32'h0);
    chk("async_w_valid", 32'(w_out_valid), 32'd0);
    out_ready = 1'b0;
    exp_q.delete();
    @(posedge clock);
    #1;
    chk("async_hold_valid", 32'(out_valid), 32'd0);

    // Restart with downstream stalled for 5 cycles
    reset_n = 1'b1;
    sb_load(32'h0, 32);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      chk("stall_head_pc", out_pc, 32'h0);
      accept_check();
    end
    chk("stall_addr", imem_address, 32'h8);
    chk("stall_valid", 32'(out_valid), 32'd1);
    chk("stall_instr", out_instruction, 32'hA000_0000);

    // Resume: stream continues with no gaps or duplicates
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      accept_check();
      @(posedge clock);
      #1;
      chk("resume_valid", 32'(out_valid), 32'd1);
    end

    // Redirect while full and stalled
    out_ready = 1'b0;
    @(posedge clock);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    sb_load(32'h40, 32);
    @(posedge clock);
    #1;
    redirect_valid = 1'b0;
    chk("redir_t1_valid", 32'(out_valid), 32'd0);
    chk("redir_t1_addr", imem_address, 32'h40);
    @(posedge clock);
    #1;
    chk("redir_t2_valid", 32'(out_valid), 32'd1);
    chk("redir_t2_pc", out_pc, 32'h40);
    chk("redir_t2_instr", out_instruction, 32'hA000_0010);
    out_ready = 1'b1;
    accept_check();
    @(posedge clock);
    #1;
    accept_check();

    // Misaligned redirect coinciding with an accepted pop
    @(posedge clock);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    chk("popredir_valid", 32'(out_valid), 32'd1);
    accept_check();
    sb_load(32'h40, 32);
    @(posedge clock);
    #1;
    redirect_valid = 1'b0;
    chk("misalign_valid", 32'(out_valid), 32'd0);
    chk("misalign_addr", imem_address, 32'h40);
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      chk("misalign_stream_valid", 32'(out_valid), 32'd1);
      accept_check();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
